// File: rtl/tc_fetch_pkg.sv
// Shared types and helpers for the fetch sequencer.
package tc_fetch_pkg;

  localparam int ADDR_W = 16;

  // Widest program word the length decoder accepts; callers zero-extend into it.
  localparam int MAX_WORD_W = 64;

  typedef enum logic [1:0] {
    START  = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  // Instruction length in words (1..4) from the 2-bit field at len_lsb of word 0.
  function automatic logic [2:0] len_decode(input logic [MAX_WORD_W-1:0] word0,
                                            input int len_lsb);
    logic [1:0] field;
    field = word0[len_lsb +: 2];
    return {1'b0, field} + 3'd1;
  endfunction

endpackage

// File: rtl/tc_fetch_sequencer_align.sv
// Combinational length decode and zero-masking of the unused instruction words.
module tc_fetch_sequencer_align
  import tc_fetch_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int LEN_LSB   = 14
) (
  input  logic [BIT_WIDTH-1:0] mem_w0,
  input  logic [BIT_WIDTH-1:0] mem_w1,
  input  logic [BIT_WIDTH-1:0] mem_w2,
  input  logic [BIT_WIDTH-1:0] mem_w3,
  output logic [2:0]           len,
  output logic [BIT_WIDTH-1:0] w0,
  output logic [BIT_WIDTH-1:0] w1,
  output logic [BIT_WIDTH-1:0] w2,
  output logic [BIT_WIDTH-1:0] w3
);

  assign len = len_decode(MAX_WORD_W'(mem_w0), LEN_LSB);

  // Word 0 always belongs to the instruction; later words only if the length covers them.
  assign w0 = mem_w0;
  assign w1 = (len >= 3'd2) ? mem_w1 : '0;
  assign w2 = (len >= 3'd3) ? mem_w2 : '0;
  assign w3 = (len == 3'd4) ? mem_w3 : '0;

endmodule

// File: rtl/tc_fetch_sequencer.sv
// Program counter, fetch FSM and memory address mux.
// Optional bounds checking is enabled with the TC_FETCH_BOUNDS_EN macro.
module tc_fetch_sequencer
  import tc_fetch_pkg::*;
#(
  parameter int                BIT_WIDTH = 16,
  parameter int                LEN_LSB   = 14,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADDR_W-1:0]    address,
  input  logic [BIT_WIDTH-1:0] mem_w0,
  input  logic [BIT_WIDTH-1:0] mem_w1,
  input  logic [BIT_WIDTH-1:0] mem_w2,
  input  logic [BIT_WIDTH-1:0] mem_w3,
  input  logic                 jump_valid,
  input  logic [ADDR_W-1:0]    jump_target,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [ADDR_W-1:0]    instr_pc,
  output logic [2:0]           instr_len,
  output logic [BIT_WIDTH-1:0] instr_w0,
  output logic [BIT_WIDTH-1:0] instr_w1,
  output logic [BIT_WIDTH-1:0] instr_w2,
  output logic [BIT_WIDTH-1:0] instr_w3,
  output logic                 fault
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, seq_pc;
  logic              over_bounds, transfer;

  tc_fetch_sequencer_align #(
    .BIT_WIDTH(BIT_WIDTH),
    .LEN_LSB  (LEN_LSB)
  ) u_align (
    .mem_w0(mem_w0),
    .mem_w1(mem_w1),
    .mem_w2(mem_w2),
    .mem_w3(mem_w3),
    .len   (instr_len),
    .w0    (instr_w0),
    .w1    (instr_w1),
    .w2    (instr_w2),
    .w3    (instr_w3)
  );

`ifdef TC_FETCH_BOUNDS_EN
  // The end address is compared in 17 bits so a PC wrap cannot hide an overrun.
  logic [ADDR_W:0] end_pc;
  assign end_pc      = {1'b0, pc} + (ADDR_W+1)'(instr_len);
  assign over_bounds = (state == RUN) && (end_pc > (ADDR_W+1)'(MEM_WORDS));
  assign fault       = over_bounds || (state == FAULT);
`else
  assign over_bounds = 1'b0;
  assign fault       = 1'b0;
`endif

  assign instr_valid = (state == RUN) && !over_bounds;
  assign instr_pc    = pc;
  assign transfer    = instr_valid && instr_ready;
  assign seq_pc      = pc + ADDR_W'(instr_len);

  // Next-state, next-PC and address mux; a jump overrides everything, including a transfer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    address    = pc;
    pc_next    = pc;
    state_next = state;
    if (jump_valid) begin
      address    = jump_target;
      pc_next    = jump_target;
      state_next = BUBBLE;
    end else begin
      case (state)
        START:   state_next = RUN;
        RUN: begin
          if (over_bounds) begin
            state_next = FAULT;
          end else if (transfer) begin
            address = seq_pc;
            pc_next = seq_pc;
          end
        end
        BUBBLE:  state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  // State and PC registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= START;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

endmodule

// File: tb/tb_tc_fetch_sequencer.sv
// Directed self-checking bench for tc_fetch_sequencer with a 1-cycle registered 4-word memory model.
module tb_tc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] address;
  logic [15:0] mem_w0, mem_w1, mem_w2, mem_w3;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_pc;
  logic [2:0]  instr_len;
  logic [15:0] instr_w0, instr_w1, instr_w2, instr_w3;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [65536];
  logic [15:0] a1, a2, a3;

  tc_fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .mem_w0     (mem_w0),
    .mem_w1     (mem_w1),
    .mem_w2     (mem_w2),
    .mem_w3     (mem_w3),
    .jump_valid (jump_valid),
    .jump_target(jump_target),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_pc   (instr_pc),
    .instr_len  (instr_len),
    .instr_w0   (instr_w0),
    .instr_w1   (instr_w1),
    .instr_w2   (instr_w2),
    .instr_w3   (instr_w3),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read of four consecutive words, addresses wrap at 16 bits.
  assign a1 = address + 16'd1;
  assign a2 = address + 16'd2;
  assign a3 = address + 16'd3;
  always @(posedge clk) begin
    mem_w0 <= mem[address];
    mem_w1 <= mem[a1];
    mem_w2 <= mem[a2];
    mem_w3 <= mem[a3];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reset, then check the two dead cycles and the first valid instruction at pc 0.
  task automatic do_reset();
    rst         = 1'b1;
    jump_valid  = 1'b0;
    jump_target = 16'h0000;
    instr_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;
    #1;
    check("start_valid", 32'(instr_valid), 32'd0);
    check("start_addr", 32'(address), 32'h0000);
    tick();
    check("run0_valid", 32'(instr_valid), 32'd1);
    check("run0_pc", 32'(instr_pc), 32'h0000);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0A00;                                  // len 1
    mem[16'h0001] = 16'h4111; mem[16'h0002] = 16'h2222;        // len 2
    mem[16'h0003] = 16'hC333; mem[16'h0004] = 16'h4444;        // len 4
    mem[16'h0005] = 16'h5555; mem[16'h0006] = 16'h6666;
    mem[16'h0007] = 16'h8777; mem[16'h0008] = 16'h8888;        // len 3
    mem[16'h0009] = 16'h9999; mem[16'h000A] = 16'h0AAA;        // len 1
    mem[16'h0040] = 16'h4ABC; mem[16'h0041] = 16'h1234;        // len 2
    mem[16'h0042] = 16'h7777;
    mem[16'h00FE] = 16'h4E0E;                                  // len 2, ends at 0x100
    mem[16'h00FF] = 16'h4F0F; mem[16'h0100] = 16'h0123;        // len 2, ends at 0x101
    mem[16'hFFFF] = 16'h4000;                                  // len 2, wraps to 0

    // Consecutive instructions of lengths 1,2,4,3 with no bubbles.
    do_reset();
    check("seq0_len", 32'(instr_len), 32'd1);
    check("seq0_w0", 32'(instr_w0), 32'h0A00);
    check("seq0_w1_masked", 32'(instr_w1), 32'h0000);
    check("seq0_addr", 32'(address), 32'h0001);
    tick();
    check("seq1_valid", 32'(instr_valid), 32'd1);
    check("seq1_pc", 32'(instr_pc), 32'h0001);
    check("seq1_len", 32'(instr_len), 32'd2);
    check("seq1_w1", 32'(instr_w1), 32'h2222);
    check("seq1_w2_masked", 32'(instr_w2), 32'h0000);
    tick();
    check("seq3_pc", 32'(instr_pc), 32'h0003);
    check("seq3_len", 32'(instr_len), 32'd4);
    check("seq3_w3", 32'(instr_w3), 32'h6666);
    tick();
    check("seq7_pc", 32'(instr_pc), 32'h0007);
    check("seq7_len", 32'(instr_len), 32'd3);
    check("seq7_w2", 32'(instr_w2), 32'h9999);
    check("seq7_w3_masked", 32'(instr_w3), 32'h0000);
    tick();
    check("seq10_valid", 32'(instr_valid), 32'd1);
    check("seq10_pc", 32'(instr_pc), 32'h000A);

    // Three stall cycles at pc 3, accept on the fourth.
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      instr_ready = 1'b0;
      #1;
      check("stall_addr", 32'(address), 32'h0003);
      check("stall_pc", 32'(instr_pc), 32'h0003);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_w0", 32'(instr_w0), 32'hC333);
      check("stall_w3", 32'(instr_w3), 32'h6666);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    check("accept_addr", 32'(address), 32'h0007);
    tick();
    check("after_stall_pc", 32'(instr_pc), 32'h0007);
    check("after_stall_valid", 32'(instr_valid), 32'd1);

    // Jump with ready=1 at pc 1: instruction dropped, one bubble, then target.
    do_reset();
    tick();
    jump_valid  = 1'b1;
    jump_target = 16'h0040;
    #1;
    check("jmp_pc_before", 32'(instr_pc), 32'h0001);
    check("jmp_addr", 32'(address), 32'h0040);
    tick();
    jump_valid = 1'b0;
    #1;
    check("jmp_bubble_valid", 32'(instr_valid), 32'd0);
    check("jmp_bubble_addr", 32'(address), 32'h0040);
    tick();
    check("jmp_target_valid", 32'(instr_valid), 32'd1);
    check("jmp_target_pc", 32'(instr_pc), 32'h0040);
    check("jmp_target_len", 32'(instr_len), 32'd2);
    check("jmp_target_w1", 32'(instr_w1), 32'h1234);
    check("jmp_target_w2_masked", 32'(instr_w2), 32'h0000);

    // Back-to-back jumps: two bubbles, first valid pc is the second target.
    do_reset();
    jump_valid  = 1'b1;
    jump_target = 16'h0010;
    tick();
    jump_target = 16'h0020;
    #1;
    check("bb_bubble1_valid", 32'(instr_valid), 32'd0);
    check("bb_bubble1_addr", 32'(address), 32'h0020);
    tick();
    jump_valid = 1'b0;
    #1;
    check("bb_bubble2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("bb_valid", 32'(instr_valid), 32'd1);
    check("bb_pc", 32'(instr_pc), 32'h0020);

    // Instruction ending exactly at the memory boundary is legal in both builds.
    do_reset();
    jump_valid  = 1'b1;
    jump_target = 16'h00FE;
    tick();
    jump_valid = 1'b0;
    tick();
    instr_ready = 1'b0;
    #1;
    check("edge_valid", 32'(instr_valid), 32'd1);
    check("edge_fault", 32'(fault), 32'd0);
    check("edge_pc", 32'(instr_pc), 32'h00FE);
    instr_ready = 1'b1;

    // Length-2 instruction at 0x00FF crosses the 256-word boundary.
    do_reset();
    jump_valid  = 1'b1;
    jump_target = 16'h00FF;
    tick();
    jump_valid = 1'b0;
    tick();
`ifdef TC_FETCH_BOUNDS_EN
    check("oob_fault", 32'(fault), 32'd1);
    check("oob_valid", 32'(instr_valid), 32'd0);
    check("oob_addr", 32'(address), 32'h00FF);
    tick();
    check("fault_sticky1", 32'(fault), 32'd1);
    check("fault_sticky1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("fault_sticky2", 32'(fault), 32'd1);
    check("fault_addr", 32'(address), 32'h00FF);
    jump_valid  = 1'b1;
    jump_target = 16'h0000;
    tick();
    jump_valid = 1'b0;
    #1;
    check("fault_clear", 32'(fault), 32'd0);
    check("fault_bubble_valid", 32'(instr_valid), 32'd0);
    tick();
    check("recover_valid", 32'(instr_valid), 32'd1);
    check("recover_pc", 32'(instr_pc), 32'h0000);
    check("recover_fault", 32'(fault), 32'd0);
`else
    check("cross_valid", 32'(instr_valid), 32'd1);
    check("cross_pc", 32'(instr_pc), 32'h00FF);
    check("cross_len", 32'(instr_len), 32'd2);
    check("cross_w1", 32'(instr_w1), 32'h0123);
    check("cross_fault", 32'(fault), 32'd0);
    check("cross_addr", 32'(address), 32'h0101);
    tick();
    check("cross_next_pc", 32'(instr_pc), 32'h0101);

    // PC wrap: length 2 at 0xFFFF continues at 0x0001.
    jump_valid  = 1'b1;
    jump_target = 16'hFFFF;
    tick();
    jump_valid = 1'b0;
    tick();
    check("wrap_pc", 32'(instr_pc), 32'hFFFF);
    check("wrap_w1", 32'(instr_w1), 32'h0A00);
    check("wrap_addr", 32'(address), 32'h0001);
    tick();
    check("wrap_next_pc", 32'(instr_pc), 32'h0001);
    check("wrap_next_valid", 32'(instr_valid), 32'd1);
`endif

    // Reset in the middle of a pending jump returns to reset values.
    jump_valid  = 1'b1;
    jump_target = 16'h0040;
    rst         = 1'b1;
    #1;
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_pc", 32'(instr_pc), 32'h0000);
    check("midrst_fault", 32'(fault), 32'd0);
    jump_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("midrst_run_pc", 32'(instr_pc), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
